// File: rtl/clk_div_arbiter_pkg.sv
// Shared state encoding and the requester limit used by the clock-source blocks.
package clk_div_arbiter_pkg;

    localparam int MAX_N_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/clk_div_arbiter_if.sv
// Requester/divider-facing bundle of the clock-divider arbiter; slave = arbiter side.
interface clk_div_arbiter_if #(
    parameter int N_REQ         = 4,
    parameter int COUNTER_WIDTH = 16,
    parameter int HOLD_WIDTH    = 8
);
    logic [N_REQ-1:0]               req;
    logic [N_REQ*COUNTER_WIDTH-1:0] req_div;
    logic [HOLD_WIDTH-1:0]          hold_edges;
    logic                           gen_clk;
    logic [COUNTER_WIDTH-1:0]       start_at;
    logic                           div_rst;
    logic [N_REQ-1:0]               grant;
    logic                           busy;
    logic                           done;

    modport master (
        output req, req_div, hold_edges, gen_clk,
        input  start_at, div_rst, grant, busy, done
    );

    modport slave (
        input  req, req_div, hold_edges, gen_clk,
        output start_at, div_rst, grant, busy, done
    );
endinterface

// File: rtl/clk_div_arbiter_rr_pick.sv
// Combinational rotating picker: first set request at or above i_ptr, wrapping.
// Latency: zero cycles; no backpressure (pure function of its inputs).
module clk_div_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_win_oh,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_any
);
    localparam logic [IDX_W:0] N_L = N_REQ[IDX_W:0];

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;

    assign w_dbl = {i_req, i_req};
    assign w_rot = N_REQ'(w_dbl >> i_ptr);
    assign o_any = |i_req;

    // Rotate so i_ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= N_L) begin
            w_sum = w_sum - N_L;
        end
        o_win_idx = w_sum[IDX_W-1:0];
        o_win_oh  = o_any ? (N_REQ'(1) << o_win_idx) : '0;
    end
endmodule

// File: rtl/clk_div_arbiter.sv
// Shares one clock divider between N_REQ requesters; CLK_ARB_FIXED_PRIO_EN selects fixed priority with req[0] preemption.
// Latency: req -> grant/busy next cycle, RUN two cycles after sampling; no backpressure, req is a held level.
module clk_div_arbiter
    import clk_div_arbiter_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int COUNTER_WIDTH = 16,
    parameter int HOLD_WIDTH    = 8
) (
    input logic              iCLK,
    input logic              iRST,
    clk_div_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > MAX_N_REQ) begin : g_bad_n_req
        $error("clk_div_arbiter: N_REQ out of range");
    end

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [N_REQ-1:0]         r_grant;
    logic [IDX_W-1:0]         r_owner;
    logic [COUNTER_WIDTH-1:0] r_start_at;
    logic [HOLD_WIDTH-1:0]    r_edge_cnt;
    logic                     r_gen_clk_q;

    logic [IDX_W-1:0]         w_ptr;
    logic [N_REQ-1:0]         w_pick_oh;
    logic [IDX_W-1:0]         w_pick_idx;
    logic                     w_pick_any;
    logic [COUNTER_WIDTH-1:0] w_pick_div;
    logic                     w_gen_rise;
    logic                     w_owner_req;
    logic                     w_limit;
    logic                     w_preempt;

`ifdef CLK_ARB_FIXED_PRIO_EN
    assign w_ptr     = '0;
    assign w_preempt = bus.req[0] && (r_owner != '0);
`else
    logic [IDX_W-1:0] r_rr_ptr;

    assign w_ptr     = r_rr_ptr;
    assign w_preempt = 1'b0;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_RELEASE) begin
            r_rr_ptr <= (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
    end
`endif

    clk_div_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req     (bus.req),
        .i_ptr     (w_ptr),
        .o_win_oh  (w_pick_oh),
        .o_win_idx (w_pick_idx),
        .o_any     (w_pick_any)
    );

    always_comb begin
        w_pick_div = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_oh[i]) begin
                w_pick_div = bus.req_div[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
        end
    end

    assign w_gen_rise  = bus.gen_clk & ~r_gen_clk_q;
    assign w_owner_req = |(bus.req & r_grant);
    // Registered count vs live hold: lowering hold below the count releases on the next edge.
    assign w_limit     = (bus.hold_edges != '0) && (r_edge_cnt >= bus.hold_edges);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.div_rst  = 1'b1;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.grant    = '0;
        bus.start_at = r_start_at;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bus.busy    = 1'b1;
                bus.grant   = r_grant;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                bus.div_rst = 1'b0;
                bus.busy    = 1'b1;
                bus.grant   = r_grant;
                if (w_limit || !w_owner_req || w_preempt) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                bus.done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_grant     <= '0;
            r_owner     <= '0;
            r_start_at  <= '0;
            r_edge_cnt  <= '0;
            r_gen_clk_q <= 1'b0;
        end else begin
            r_gen_clk_q <= bus.gen_clk;
            if (r_state == ST_IDLE && w_pick_any) begin
                r_grant    <= w_pick_oh;
                r_owner    <= w_pick_idx;
                r_start_at <= w_pick_div;
            end
            if (r_state == ST_LOAD) begin
                r_edge_cnt <= '0;
            end else if (r_state == ST_RUN && w_gen_rise && r_edge_cnt != '1) begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_arbiter.sv
// Bench for clk_div_arbiter: directed vector table, corner sequences, then random traffic against a reference model.
module tb_clk_div_arbiter;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int HW = 8;
    localparam logic [N*CW-1:0] DIVS = {16'hABCD, 16'h2233, 16'd3, 16'h0011};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    clk_div_arbiter_if #(.N_REQ(N), .COUNTER_WIDTH(CW), .HOLD_WIDTH(HW)) bus ();

    clk_div_arbiter #(.N_REQ(N), .COUNTER_WIDTH(CW), .HOLD_WIDTH(HW)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  req;
        logic [HW-1:0] hold;
        int            drop;
        logic [N-1:0]  exp_grant;
        logic [CW-1:0] exp_start;
        int            exp_done;
    } vec_t;

    vec_t vt[6];

    // Reference model: owner index (-1 idle), age since grant, counted edges, release flag.
    int m_owner, m_age, m_edges, m_ptr;
    logic [CW-1:0] m_start;
    bit m_rel, m_gq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_owner = -1; m_age = 0; m_edges = 0; m_ptr = 0;
        m_start = '0; m_rel = 0; m_gq = 0;
    endtask

    task automatic m_step();
        bit rise, stop;
        int w, c;
        logic [N-1:0] rq;
        rq   = bus.req;
        rise = bus.gen_clk && !m_gq;
        m_gq = bus.gen_clk;
        if (m_rel) begin
            m_rel = 0;
`ifndef CLK_ARB_FIXED_PRIO_EN
            m_ptr = (m_owner + 1) % N;
`endif
            m_owner = -1;
        end else if (m_owner < 0) begin
            w = -1;
            for (int o = 0; o < N; o++) begin
                c = (m_ptr + o) % N;
                if (rq[c] && w < 0) w = c;
            end
            if (w >= 0) begin
                m_owner = w;
                m_start = bus.req_div[w*CW +: CW];
                m_age   = 0;
            end
        end else if (m_age == 0) begin
            m_age   = 1;
            m_edges = 0;
        end else begin
            stop = (bus.hold_edges != 0 && m_edges >= int'(bus.hold_edges)) || !rq[m_owner];
`ifdef CLK_ARB_FIXED_PRIO_EN
            if (m_owner != 0 && rq[0]) stop = 1;
`endif
            if (rise && m_edges < (1 << HW) - 1) m_edges++;
            if (stop) m_rel = 1;
        end
    endtask

    task automatic cmp_model();
        bit busy;
        logic [N-1:0] g;
        busy = (m_owner >= 0) && !m_rel;
        g    = busy ? N'(1 << m_owner) : '0;
        chk("model", {bus.grant, bus.start_at, bus.div_rst, bus.busy, bus.done},
                     {g, m_start, !(busy && m_age >= 1), busy, m_rel});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0; bus.hold_edges = '0; bus.gen_clk = 1'b0; bus.req_div = DIVS;
        #1;
        chk("reset_state", {bus.grant, bus.start_at, bus.div_rst, bus.busy, bus.done},
                           {4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_run(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            bus.gen_clk = ~bus.gen_clk;
            if (bus.busy && !bus.div_rst) ok = 1;
        end
        chk(name, ok, 1'b1);
    endtask

    initial begin
        int done_t;
        bit got;
        logic [N-1:0] prev, seen[$], exp_seq[5];

        vt[0] = '{4'b0010, 8'd2, 0, 4'b0010, 16'd3,    5};
        vt[1] = '{4'b0001, 8'd1, 0, 4'b0001, 16'h0011, 3};
        vt[2] = '{4'b1000, 8'd3, 0, 4'b1000, 16'hABCD, 7};
        vt[3] = '{4'b0100, 8'd0, 5, 4'b0100, 16'h2233, 11};
        vt[4] = '{4'b1100, 8'd2, 2, 4'b0100, 16'h2233, 5};
        vt[5] = '{4'b1010, 8'd1, 0, 4'b0010, 16'd3,    3};

        bus.req = '0; bus.hold_edges = '0; bus.gen_clk = 1'b0; bus.req_div = DIVS;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.req = vt[v].req;
            bus.hold_edges = vt[v].hold;
            got = 0;
            for (int k = 0; k < 5 && !got; k++) begin
                @(negedge clk);
                if (bus.grant != '0) got = 1;
            end
            chk($sformatf("v%0d_grant_seen", v), got, 1'b1);
            chk($sformatf("v%0d_grant", v), bus.grant, vt[v].exp_grant);
            chk($sformatf("v%0d_start_at", v), bus.start_at, vt[v].exp_start);
            chk($sformatf("v%0d_load", v), {bus.busy, bus.div_rst}, 2'b11);
            done_t = -1;
            for (int t = 1; t <= 40 && done_t < 0; t++) begin
                @(negedge clk);
                if (t == 1) chk($sformatf("v%0d_run_div_rst", v), bus.div_rst, 1'b0);
                if (bus.done) begin
                    done_t = t;
                end else begin
                    bus.gen_clk = t[0];
                    if (vt[v].drop != 0 && t == 2 * vt[v].drop) bus.req = '0;
                end
            end
            chk($sformatf("v%0d_done_time", v), done_t, vt[v].exp_done);
            chk($sformatf("v%0d_grant_at_done", v), {bus.grant, bus.busy}, '0);
            bus.gen_clk = 1'b0;
            bus.req = (v == 0) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", v), bus.done, 1'b0);
            @(negedge clk);
            if (v == 0) begin
`ifdef CLK_ARB_FIXED_PRIO_EN
                chk("v0_next_winner", bus.grant, 4'b0001);
`else
                chk("v0_next_winner", bus.grant, 4'b0100);
`endif
            end else begin
                chk($sformatf("v%0d_no_regrant", v), bus.grant, 4'b0000);
            end
        end

        // Round-robin rotation with all requesters held.
        do_reset();
        bus.req = 4'b1111;
        bus.hold_edges = 8'd1;
        prev = '0;
        for (int k = 0; k < 100 && seen.size() < 5; k++) begin
            @(negedge clk);
            bus.gen_clk = ~bus.gen_clk;
            if (bus.grant != '0 && prev == '0) seen.push_back(bus.grant);
            prev = bus.grant;
        end
`ifdef CLK_ARB_FIXED_PRIO_EN
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        chk("rr_count", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) begin
            chk($sformatf("rr_grant%0d", i), seen[i], exp_seq[i]);
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        bus.req = 4'b0100;
        wait_run("rst_reach_run");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_run", {bus.grant, bus.div_rst, bus.busy, bus.done}, {4'b0000, 1'b1, 1'b0, 1'b0});

        // Requester 0 arriving while requester 3 runs.
        do_reset();
        bus.req = 4'b1000;
        wait_run("pre_reach_run");
        bus.req = 4'b1001;
        @(negedge clk);
`ifdef CLK_ARB_FIXED_PRIO_EN
        chk("pre_release", {bus.done, bus.grant}, {1'b1, 4'b0000});
        @(negedge clk);
        @(negedge clk);
        chk("pre_new_owner", bus.grant, 4'b0001);
`else
        chk("pre_no_preempt", {bus.done, bus.grant}, {1'b0, 4'b1000});
        @(negedge clk);
        chk("pre_still_owner", bus.grant, 4'b1000);
`endif

        // Random traffic against the reference model.
        do_reset();
        m_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) bus.req[i] = ~bus.req[i];
            end
            if ($urandom_range(0, 19) == 0) bus.hold_edges = HW'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) bus.req_div = {$urandom, $urandom};
            bus.gen_clk = 1'($urandom_range(0, 1));
            m_step();
            @(negedge clk);
            cmp_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
